// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults (common with the APB slave memory)
// and the requester FSM state encoding.
package apb_pkg;

   localparam int unsigned APB_AWIDTH = 8;
   localparam int unsigned APB_DWIDTH = 32;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } apb_master_state_e;

endpackage

// File: rtl/apb_master_wdog.sv
// ACCESS-phase watchdog for apb_master. Counts stalled ACCESS cycles and flags
// the cycle in which the TIMEOUT_CYCLES-th consecutive stall completes.
module apb_master_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Stall counter: cleared outside ACCESS, bumped on every stalled ACCESS cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (count) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // cnt_q holds the number of earlier stalled cycles, so the current stall is
   // number cnt_q + 1.
   assign expired = count && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB transfers and
// returns one response per command. All outputs are registered.
// Optional: define APB_MASTER_TIMEOUT_EN to abort transfers whose ACCESS phase
// stalls for TIMEOUT_CYCLES cycles (response then carries rsp_err = 1).
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned AWIDTH         = APB_AWIDTH,
   parameter int unsigned DWIDTH         = APB_DWIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   // command stream
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [DWIDTH-1:0] cmd_wdata,
   // response stream
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   // APB
   output logic              p_sel,
   output logic              p_en,
   output logic              p_write,
   output logic [AWIDTH-1:0] addr,
   output logic [DWIDTH-1:0] wdata,
   input  logic [DWIDTH-1:0] rdata,
   input  logic              p_ready
);

   apb_master_state_e state_q, state_d;

   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              p_sel_q, p_sel_d;
   logic              p_en_q, p_en_d;
   logic              p_write_q, p_write_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;

   logic wdog_expired;

`ifdef APB_MASTER_TIMEOUT_EN
   logic wdog_clear;
   logic wdog_count;

   assign wdog_clear = (state_q != StAccess);
   assign wdog_count = (state_q == StAccess) && !p_ready;

   apb_master_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wdog_clear),
      .count  (wdog_count),
      .expired(wdog_expired)
   );
`else
   assign wdog_expired = 1'b0;
`endif

   // Next-state and registered-output logic; every register holds by default.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      p_sel_d     = p_sel_q;
      p_en_d      = p_en_q;
      p_write_d   = p_write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;

      unique case (state_q)
         StIdle: begin
            // Also raises cmd_ready on the first edge after reset release.
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               p_write_d   = cmd_write;
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               p_sel_d     = 1'b1;
               p_en_d      = 1'b0;
               state_d     = StSetup;
            end
         end
         StSetup: begin
            // p_ready here may be stale from the previous transfer: ignore it.
            p_en_d  = 1'b1;
            state_d = StAccess;
         end
         StAccess: begin
            if (p_ready || wdog_expired) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = p_write_q;
               rsp_err_d   = !p_ready;
               rsp_rdata_d = (p_ready && !p_write_q) ? rdata : '0;
               p_sel_d     = 1'b0;
               p_en_d      = 1'b0;
               p_write_d   = 1'b0;
               addr_d      = '0;
               wdata_d     = '0;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_write_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         p_sel_q     <= 1'b0;
         p_en_q      <= 1'b0;
         p_write_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         p_sel_q     <= p_sel_d;
         p_en_q      <= p_en_d;
         p_write_q   <= p_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign p_sel     = p_sel_q;
   assign p_en      = p_en_q;
   assign p_write   = p_write_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a behavioural APB slave memory whose
// registered p_ready stays stale-high into the next SETUP cycle.
// Honours APB_MASTER_TIMEOUT_EN for the stalled-slave checks.
module tb_apb_master;
   import apb_pkg::*;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          p_sel, p_en, p_write;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          p_ready;

   int checks = 0;
   int failures = 0;
   int setup_cnt = 0;
   int rsp_cnt = 0;

   apb_master #(
      .AWIDTH(AW),
      .DWIDTH(DW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .p_sel    (p_sel),
      .p_en     (p_en),
      .p_write  (p_write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .p_ready  (p_ready)
   );

   always #5 clk = ~clk;

   // Slave memory: p_ready low in the first ACCESS cycle, high in the second,
   // then left high (stale) until the next SETUP is seen. stall models a dead slave.
   logic [DW-1:0] mem [256] = '{default: '0};
   logic          p_ready_q = 1'b0;
   logic          stall = 1'b0;

   assign p_ready = stall ? 1'b0 : p_ready_q;
   assign rdata   = mem[addr];

   always @(posedge clk) begin
      if (p_sel && !p_en) begin
         p_ready_q <= 1'b0;
      end else if (p_sel && p_en) begin
         p_ready_q <= 1'b1;
         if (p_ready && p_write) mem[addr] <= wdata;
      end
   end

   // Count SETUP cycles and consumed responses.
   always @(negedge clk) if (rst && p_sel && !p_en) setup_cnt <= setup_cnt + 1;
   always @(posedge clk) if (rst && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, p_sel, p_en, p_write,
              addr, wdata};
   endfunction

   // Present a command and wait for the accept edge; returns 1 ns after it.
   task automatic start_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit keep);
      bit ok = 1'b0;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(posedge clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
      if (!ok) check_eq("accept_timeout", 0, 1);
   endtask

   // Full transfer with response checks; hold > 0 keeps rsp_ready low that many cycles.
   task automatic xfer(input string tag, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit keep, input int hold,
                       input logic [DW-1:0] exp_rd);
      int lat = 0;
      int setup_base = setup_cnt;
      bit seen = 1'b0;
      if (hold > 0) rsp_ready = 1'b0;
      start_cmd(w, a, d, keep);
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat  = i;
            seen = 1'b1;
            break;
         end
      end
      check_eq({tag, "_seen"}, seen, 1);
      check_eq({tag, "_lat"}, lat, 4);
      check_eq({tag, "_setups"}, setup_cnt - setup_base, 1);
      check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
      check_eq({tag, "_write"}, rsp_write, w);
      check_eq({tag, "_err"}, rsp_err, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, "_bp_valid"}, rsp_valid, 1);
         check_eq({tag, "_bp_rdata"}, rsp_rdata, exp_rd);
         check_eq({tag, "_bp_cmdrdy"}, cmd_ready, 0);
         check_eq({tag, "_bp_psel"}, p_sel, 0);
      end
      rsp_ready = 1'b1;
   endtask

   initial begin
      int base;
      int n;
      #2;
      check_eq("por_outputs", all_outs(), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("por_cmd_ready_low", cmd_ready, 0);
      @(posedge clk);
      #1;
      check_eq("por_cmd_ready_rise", cmd_ready, 1);

      // Write then read
      xfer("wr10", 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 0, 32'h0);
      xfer("rd10", 1'b0, 8'h10, 32'h0, 1'b0, 0, 32'hDEADBEEF);

      // Reset pulse during SETUP
      start_cmd(1'b1, 8'h55, 32'h0000AAAA, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_pulse_outputs", all_outs(), 0);
      @(negedge clk);
      rst = 1'b1;
      xfer("rd42", 1'b0, 8'h42, 32'h0, 1'b0, 0, 32'h0);

      // Back-to-back with cmd_valid held high
      @(negedge clk);
      base = rsp_cnt;
      xfer("b2b_w0", 1'b1, 8'h00, 32'd1, 1'b1, 0, 32'h0);
      xfer("b2b_wff", 1'b1, 8'hFF, 32'd2, 1'b1, 0, 32'h0);
      xfer("b2b_w1", 1'b1, 8'h01, 32'd3, 1'b1, 0, 32'h0);
      xfer("b2b_r0", 1'b0, 8'h00, 32'h0, 1'b1, 0, 32'd1);
      xfer("b2b_rff", 1'b0, 8'hFF, 32'h0, 1'b1, 0, 32'd2);
      xfer("b2b_r1", 1'b0, 8'h01, 32'h0, 1'b0, 0, 32'd3);
      @(negedge clk);
      check_eq("b2b_rsp_count", rsp_cnt - base, 6);

      // Back-pressure
      xfer("bp_rdff", 1'b0, 8'hFF, 32'h0, 1'b0, 5, 32'd2);
      @(negedge clk);
      check_eq("bp_released", rsp_valid, 0);

      // Stalled slave
      stall = 1'b1;
      start_cmd(1'b0, 8'h30, 32'h0, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
         if (p_sel && p_en) n++;
      end
      check_eq("to_access_cycles", n, 16);
      check_eq("to_valid", rsp_valid, 1);
      check_eq("to_err", rsp_err, 1);
      check_eq("to_rdata", rsp_rdata, 0);
      check_eq("to_psel", p_sel, 0);
      @(negedge clk);
      stall = 1'b0;
      check_eq("to_consumed", rsp_valid, 0);
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      check_eq("nto_no_rsp", n, 0);
      check_eq("nto_still_access", {p_sel, p_en}, 2'b11);
      rst = 1'b0;
      #1;
      check_eq("nto_rst_outputs", all_outs(), 0);
      @(negedge clk);
      rst = 1'b1;
      stall = 1'b0;
`endif

      // Reset mid-ACCESS
      @(negedge clk);
      base = rsp_cnt;
      start_cmd(1'b1, 8'h20, 32'hCAFEF00D, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check_eq("mid_in_access", {p_sel, p_en}, 2'b11);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_outputs", all_outs(), 0);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      check_eq("mid_no_rsp_valid", n, 0);
      check_eq("mid_no_rsp_count", rsp_cnt - base, 0);
      xfer("wr20", 1'b1, 8'h20, 32'h12345678, 1'b0, 0, 32'h0);
      xfer("rd20", 1'b0, 8'h20, 32'h0, 1'b0, 0, 32'h12345678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
